ifetch_unit: RTL

Instruction fetch stage directly upstream of the single-cycle control unit (CU).
- Holds the PC and issues word fetches to instruction memory over a valid/ready request plus a response-valid return.
- Presents the held instruction and its opcode/func fields to CU and the datapath until they are acknowledged.
- On acknowledge, computes the next PC (sequential, beq-taken, or j) from CU Branch/Jump and ALU Zero.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/ifetch_next_pc.sv | 34 +++
 rtl/ifetch_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: opcodes, fetch FSM states,
// reset PC and instruction width.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] J      = 6'b000010;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_next_pc.sv
// Next-PC selection for the fetch stage: jump, taken beq, or sequential.
// Purely combinational; jump has priority over branch.
module ifetch_next_pc
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  pc_plus4,
  input  logic [INSTR_W-1:0] instr,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  output logic [ADDR_W-1:0]  next_pc
);

  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_off;
  logic              unused_opcode;

  assign jump_target   = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
  assign branch_off    = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign unused_opcode = ^instr[31:26];

  // Priority select of the following PC.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: requests a word at pc, holds the returned
// instruction for the control unit until acknowledged, then advances pc.
// Optional macro IFETCH_PERF_CNT_EN adds fetch / wait-cycle counters.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [5:0]          opcode,
  output logic [5:0]          func,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_plus4,
  input  logic                instr_ack,
  input  logic                branch,
  input  logic                zero,
  input  logic                jump
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetches,
  output logic [31:0]         perf_wait_cycles
`endif
);

  fetch_state_t       state, state_nxt;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  next_pc;
  logic [INSTR_W-1:0] instr_q;
  logic               capture;
  logic               retire;

  ifetch_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .next_pc  (next_pc)
  );

  // Next-state logic; capture/retire flag the datapath updates.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    retire    = 1'b0;
    unique case (state)
      REQ:  if (imem_req_ready) state_nxt = WAIT;
      WAIT: if (imem_rsp_valid) begin
              state_nxt = HOLD;
              capture   = 1'b1;
            end
      HOLD: if (instr_ack) begin
              state_nxt = REQ;
              retire    = 1'b1;
            end
      default: state_nxt = REQ;
    endcase
  end

  // State, PC and held-instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= REQ;
      pc_q    <= PC_RESET;
      instr_q <= '0;
    end else begin
      state <= state_nxt;
      if (capture) instr_q <= imem_rsp_data;
      if (retire)  pc_q    <= next_pc;
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc_q;
  assign instr_valid    = (state == HOLD);
  assign instr          = instr_q;
  assign opcode         = instr_q[31:26];
  assign func           = instr_q[5:0];
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + ADDR_W'(4);

`ifdef IFETCH_PERF_CNT_EN
  logic stalled;
  assign stalled = ((state == REQ)  && !imem_req_ready) ||
                   ((state == WAIT) && !imem_rsp_valid);

  // Retired-fetch and stall-cycle counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetches     <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (retire)  perf_fetches     <= perf_fetches + 32'd1;
      if (stalled) perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule
